// File: rtl/ttl_sync_pkg.sv
// -----------------------------------------------------------------------------
// ttl_sync_pkg
//
// Shared definitions for the synchronous TTL model family (*_sync stages).
//
// Contents:
//   ACC_W_DEFAULT  default phase-accumulator / ratio width
//   ratio_ok()     legality of a Num/Den enable ratio: Den must be non-zero
//                  and 2*Num must not exceed Den, so every strobe is followed
//                  by at least one idle cycle.
// -----------------------------------------------------------------------------
package ttl_sync_pkg;

    localparam int unsigned ACC_W_DEFAULT = 16;

    // Arguments are zero-extended to 32 bits by the caller; the doubled
    // numerator is compared in 33 bits so it can never overflow.
    function automatic logic ratio_ok(input logic [31:0] num, input logic [31:0] den);
        logic [32:0] num_x2;
        logic [32:0] den_x;
        num_x2 = {num, 1'b0};
        den_x  = {1'b0, den};
        return (den != '0) && (num_x2 <= den_x);
    endfunction

endpackage : ttl_sync_pkg

// File: rtl/ttl_cen_gen_sync.sv
// -----------------------------------------------------------------------------
// ttl_cen_gen_sync
//
// Fractional clock-enable generator. A phase accumulator adds Num each run
// cycle and subtracts Den on overflow, giving an average Cen rate of Num/Den
// per Clk. A second strobe marks the half-period crossing and Phase is a
// square wave that is high during the second half of each period.
//
// Ratios are written through a shadow register and applied only at a period
// boundary (a Cen wrap) or while the generator is stopped, so a running
// period is never cut short by a ratio change.
//
// Parameters:
//   ACC_W        width of accumulator, Num and Den (>= 2, <= 32)
//   DEFAULT_NUM  numerator loaded at reset
//   DEFAULT_DEN  denominator loaded at reset
//
// Ports:
//   Clk          system clock
//   Reset_bar    synchronous active-low reset
//   Run          1 = advance accumulator, 0 = freeze
//   Num_in       new numerator
//   Den_in       new denominator
//   Ratio_load   1-cycle strobe capturing Num_in/Den_in into the shadow
//   Cen          main enable strobe, one cycle wide
//   Cen_half     half-period strobe, one cycle wide
//   Phase        0 in first half of period, 1 in second half
//   Load_pend    shadow ratio captured but not yet applied
//   Ratio_err    active ratio is illegal (clamped, or stopped for Den = 0)
// -----------------------------------------------------------------------------
module ttl_cen_gen_sync
    import ttl_sync_pkg::*;
#(
    parameter int unsigned ACC_W       = ACC_W_DEFAULT,
    parameter int unsigned DEFAULT_NUM = 1,
    parameter int unsigned DEFAULT_DEN = 4
) (
    input  logic             Clk,
    input  logic             Reset_bar,
    input  logic             Run,
    input  logic [ACC_W-1:0] Num_in,
    input  logic [ACC_W-1:0] Den_in,
    input  logic             Ratio_load,
    output logic             Cen,
    output logic             Cen_half,
    output logic             Phase,
    output logic             Load_pend,
    output logic             Ratio_err
);

    localparam logic [ACC_W-1:0] RST_NUM = ACC_W'(DEFAULT_NUM);
    localparam logic [ACC_W-1:0] RST_DEN = ACC_W'(DEFAULT_DEN);
    localparam logic             RST_ERR = !ratio_ok(32'(DEFAULT_NUM), 32'(DEFAULT_DEN));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // The accumulator carries one extra bit: acc < den and num_eff <= den/2,
    // so acc + num_eff stays below 1.5 * 2^ACC_W.
    logic [ACC_W:0]   acc_q,       acc_d;
    logic [ACC_W-1:0] num_q,       num_d;
    logic [ACC_W-1:0] den_q,       den_d;
    logic [ACC_W-1:0] shd_num_q,   shd_num_d;
    logic [ACC_W-1:0] shd_den_q,   shd_den_d;
    logic             cen_q,       cen_d;
    logic             cen_half_q,  cen_half_d;
    logic             phase_q,     phase_d;
    logic             load_pend_q, load_pend_d;
    logic             ratio_err_q, ratio_err_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic             den_zero;
    logic [ACC_W:0]   den_x;
    logic [ACC_W:0]   half_x;
    logic [ACC_W:0]   num_eff_x;
    logic [ACC_W:0]   sum;
    logic             step;
    logic             wrap;
    logic             apply;

    always_comb begin
        den_zero = (den_q == '0);
        den_x    = {1'b0, den_q};
        half_x   = {2'b00, den_q[ACC_W-1:1]};

        // Ratios above 1/2 are clamped to exactly 1/2 so Cen still has a
        // low cycle between pulses.
        if ({num_q, 1'b0} > den_x) begin
            num_eff_x = half_x;
        end else begin
            num_eff_x = {1'b0, num_q};
        end

        sum   = acc_q + num_eff_x;
        step  = Run && !den_zero;
        wrap  = step && (sum >= den_x);
        // A pending ratio lands on a period boundary or whenever stopped.
        apply = load_pend_q && (!Run || wrap);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        acc_d       = acc_q;
        num_d       = num_q;
        den_d       = den_q;
        shd_num_d   = shd_num_q;
        shd_den_d   = shd_den_q;
        cen_d       = 1'b0;
        cen_half_d  = 1'b0;
        phase_d     = phase_q;
        load_pend_d = load_pend_q;
        // Legality is registered from the active ratio, so it trails a
        // ratio change by one cycle.
        ratio_err_d = !ratio_ok(32'(num_q), 32'(den_q));

        if (step) begin
            acc_d      = wrap ? (sum - den_x) : sum;
            cen_d      = wrap;
            cen_half_d = (acc_q < half_x) && (sum >= half_x) && !wrap;
        end

        if (apply) begin
            num_d       = shd_num_q;
            den_d       = shd_den_q;
            acc_d       = '0;
            load_pend_d = 1'b0;
        end

        // Phase follows the accumulator value actually stored, including the
        // restart at zero when a new ratio is applied on a wrap.
        if (step) begin
            phase_d = (acc_d >= half_x);
        end

        // A capture on the same edge as an apply wins: the apply consumes
        // the old shadow, the new values stay pending.
        if (Ratio_load) begin
            shd_num_d   = Num_in;
            shd_den_d   = Den_in;
            load_pend_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (!Reset_bar) begin
            acc_q       <= '0;
            num_q       <= RST_NUM;
            den_q       <= RST_DEN;
            shd_num_q   <= RST_NUM;
            shd_den_q   <= RST_DEN;
            cen_q       <= 1'b0;
            cen_half_q  <= 1'b0;
            phase_q     <= 1'b0;
            load_pend_q <= 1'b0;
            ratio_err_q <= RST_ERR;
        end else begin
            acc_q       <= acc_d;
            num_q       <= num_d;
            den_q       <= den_d;
            shd_num_q   <= shd_num_d;
            shd_den_q   <= shd_den_d;
            cen_q       <= cen_d;
            cen_half_q  <= cen_half_d;
            phase_q     <= phase_d;
            load_pend_q <= load_pend_d;
            ratio_err_q <= ratio_err_d;
        end
    end

    assign Cen       = cen_q;
    assign Cen_half  = cen_half_q;
    assign Phase     = phase_q;
    assign Load_pend = load_pend_q;
    assign Ratio_err = ratio_err_q;

endmodule : ttl_cen_gen_sync

// File: tb/tb_ttl_cen_gen_sync.sv
// -----------------------------------------------------------------------------
// tb_ttl_cen_gen_sync
//
// Self-checking bench for ttl_cen_gen_sync. The reference model counts run
// steps since the last ratio change and derives every output arithmetically
// from that count: the accumulator after n steps is (n * num_eff) mod den.
// Directed sequences pin the model with hand-computed strobe positions, then
// a long randomized run is checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_ttl_cen_gen_sync;

    localparam int DN = 1;
    localparam int DD = 4;

    logic        Clk        = 1'b0;
    logic        Reset_bar  = 1'b0;
    logic        Run        = 1'b0;
    logic        Ratio_load = 1'b0;
    logic [15:0] Num_in     = '0;
    logic [15:0] Den_in     = '0;
    logic        Cen;
    logic        Cen_half;
    logic        Phase;
    logic        Load_pend;
    logic        Ratio_err;

    ttl_cen_gen_sync #(
        .ACC_W       (16),
        .DEFAULT_NUM (DN),
        .DEFAULT_DEN (DD)
    ) dut (
        .Clk        (Clk),
        .Reset_bar  (Reset_bar),
        .Run        (Run),
        .Num_in     (Num_in),
        .Den_in     (Den_in),
        .Ratio_load (Ratio_load),
        .Cen        (Cen),
        .Cen_half   (Cen_half),
        .Phase      (Phase),
        .Load_pend  (Load_pend),
        .Ratio_err  (Ratio_err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    longint m_num, m_den, m_shn, m_shd, m_n;
    bit     m_pend, m_cen, m_half, m_phase, m_err;
    bit     prev_cen;

    function automatic bit legal(input longint n, input longint d);
        return (d != 0) && (2 * n <= d);
    endfunction

    function automatic longint eff(input longint n, input longint d);
        return (2 * n > d) ? (d / 2) : n;
    endfunction

    task automatic model_step(input bit rst, input bit run, input bit load,
                              input longint nin, input longint din);
        longint ne, h, a, s;
        bit     step, err_next;
        if (!rst) begin
            m_num = DN; m_den = DD; m_shn = DN; m_shd = DD;
            m_pend = 0; m_n = 0; m_cen = 0; m_half = 0; m_phase = 0;
            m_err = !legal(DN, DD);
            return;
        end
        err_next = !legal(m_num, m_den);
        ne   = eff(m_num, m_den);
        h    = m_den / 2;
        step = run && (m_den != 0);
        m_cen  = 0;
        m_half = 0;
        if (step) begin
            a = (m_n * ne) % m_den;
            s = a + ne;
            m_cen  = (s >= m_den);
            m_half = (a < h) && (s >= h) && (s < m_den);
            m_n++;
        end
        if (m_pend && (!run || m_cen)) begin
            m_num = m_shn; m_den = m_shd; m_pend = 0;
            if (step) m_phase = (0 >= h);
            m_n = 0;
        end else if (step) begin
            m_phase = (((m_n * ne) % m_den) >= h);
        end
        if (load) begin
            m_shn = nin; m_shd = din; m_pend = 1;
        end
        m_err = err_next;
    endtask

    task automatic compare_all();
        check("cen",       Cen,       m_cen);
        check("cen_half",  Cen_half,  m_half);
        check("phase",     Phase,     m_phase);
        check("load_pend", Load_pend, m_pend);
        check("ratio_err", Ratio_err, m_err);
        check("cen_gap",   prev_cen && Cen, 0);
        check("cen_excl",  Cen && Cen_half, 0);
        prev_cen = Cen;
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 ns later.
    task automatic cycle(input bit rst, input bit run, input bit load,
                         input int nin, input int din);
        Reset_bar  = rst;
        Run        = run;
        Ratio_load = load;
        Num_in     = 16'(nin);
        Den_in     = 16'(din);
        @(posedge Clk);
        model_step(rst, run, load, nin, din);
        #1;
        compare_all();
    endtask

    task automatic set_ratio_stopped(input int n, input int d);
        cycle(1, 0, 1, n, d);
        cycle(1, 0, 0, 0, 0);
    endtask

    initial begin
        int     pat[4] = '{0, 1, 1, 0};
        int     p2_exp[9] = '{3, 6, 8, 11, 14, 16, 19, 22, 24};
        int     got_edges[$];
        logic   ph_hold;
        prev_cen = 0;

        // Reset state
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 7, 9);
        check("rst_cen",   Cen, 0);
        check("rst_half",  Cen_half, 0);
        check("rst_phase", Phase, 0);
        check("rst_pend",  Load_pend, 0);
        check("rst_err",   Ratio_err, 0);

        // 1/4: Cen at 4,8,12; Cen_half at 2,6,10; Phase 0,1,1,0
        for (int e = 1; e <= 12; e++) begin
            cycle(1, 1, 0, 0, 0);
            check("p14_cen",   Cen,      (e % 4 == 0) ? 1 : 0);
            check("p14_half",  Cen_half, (e % 4 == 2) ? 1 : 0);
            check("p14_phase", Phase,    pat[(e - 1) % 4]);
        end

        // 3/8: three pulses per eight cycles, spacings 3,3,2
        set_ratio_stopped(3, 8);
        for (int e = 1; e <= 24; e++) begin
            cycle(1, 1, 0, 0, 0);
            if (Cen) got_edges.push_back(e);
        end
        check("p38_count", got_edges.size(), 9);
        for (int i = 0; i < 9 && i < got_edges.size(); i++)
            check("p38_edge", got_edges[i], p2_exp[i]);

        // 5/8 clamps to 4/8: error flag, Cen every second cycle
        set_ratio_stopped(5, 8);
        for (int e = 1; e <= 8; e++) begin
            cycle(1, 1, 0, 0, 0);
            check("p58_err",  Ratio_err, 1);
            check("p58_cen",  Cen,      (e % 2 == 0) ? 1 : 0);
            check("p58_half", Cen_half, (e % 2 == 1) ? 1 : 0);
        end

        // Den = 0 freezes everything
        set_ratio_stopped(1, 0);
        ph_hold = Phase;
        for (int e = 1; e <= 6; e++) begin
            cycle(1, 1, 0, 0, 0);
            check("d0_err",   Ratio_err, 1);
            check("d0_cen",   Cen, 0);
            check("d0_half",  Cen_half, 0);
            check("d0_phase", Phase, ph_hold);
        end
        // Recovery to 1/2
        set_ratio_stopped(1, 2);
        for (int e = 1; e <= 4; e++) begin
            cycle(1, 1, 0, 0, 0);
            check("p12_err", Ratio_err, 0);
            check("p12_cen", Cen, (e % 2 == 0) ? 1 : 0);
        end

        // Mid-run 1/4 -> 1/3 issued one cycle after a Cen
        set_ratio_stopped(1, 4);
        for (int e = 1; e <= 14; e++) begin
            cycle(1, 1, (e == 5) ? 1'b1 : 1'b0, 1, 3);
            if (e >= 5 && e <= 7) check("mid_pend", Load_pend, 1);
            if (e == 8) check("mid_pend_clr", Load_pend, 0);
            check("mid_cen", Cen, (e == 4 || e == 8 || e == 11 || e == 14) ? 1 : 0);
        end

        // Reset at acc = 3 with a Ratio_load on the same edge
        set_ratio_stopped(1, 4);
        for (int e = 1; e <= 3; e++) cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 1, 3, 8);
        check("mrst_cen",   Cen, 0);
        check("mrst_half",  Cen_half, 0);
        check("mrst_phase", Phase, 0);
        check("mrst_pend",  Load_pend, 0);
        check("mrst_err",   Ratio_err, 0);
        for (int e = 1; e <= 4; e++) begin
            cycle(1, 1, 0, 0, 0);
            check("mrst_pend2", Load_pend, 0);
            check("mrst_cen2",  Cen, (e == 4) ? 1 : 0);
        end

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            bit rst, run, load;
            int nin, din;
            rst  = ($urandom_range(0, 199) != 0);
            run  = ($urandom_range(0, 9) < 7);
            load = ($urandom_range(0, 19) == 0);
            din  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
            nin  = int'($urandom_range(0, 10));
            cycle(rst, run, load, nin, din);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ttl_cen_gen_sync
